// File: rtl/coin_scheduler_pkg.sv
// Shared constants, status bit positions and FSM state type for coin_scheduler and lfsr16.
package coin_pkg;

   localparam int NUM_COINS    = 3;
   localparam int SPACING_BASE = 120;
   localparam int INIT_X_BASE  = 400;
   localparam int INIT_X_STEP  = 200;
   localparam int RESET_Y      = 360;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // One-hot status = {wait, play, win, lose}
   localparam int ST_WAIT = 3;
   localparam int ST_PLAY = 2;
   localparam int ST_WIN  = 1;
   localparam int ST_LOSE = 0;

   typedef enum logic [1:0] {IDLE, RUN, FREEZE} state_t;

endpackage

// File: rtl/coin_scheduler_lfsr16.sv
// 16-bit Fibonacci LFSR, advanced once per enable; also used for hazard placement.
module lfsr16
   import coin_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        en_i,
   output logic [15:0] state_o
);

   logic [15:0] lfsr_q;

   always_ff @(posedge Clk) begin
      if (Reset)
         lfsr_q <= LFSR_SEED;
      else if (en_i)
         lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   end

   assign state_o = lfsr_q;

endmodule

// File: rtl/coin_scheduler.sv
// Coin slot placement, retirement, respawn and scoring, advanced per synchronized frame tick.
// Build option: define COIN_RANDOM_Y_EN for LFSR-jittered coin heights.
module coin_scheduler
   import coin_pkg::*;
#(
   parameter int NUM_COINS = coin_pkg::NUM_COINS,
   parameter int SCREEN_W  = 640,
   parameter int COIN_W    = 16
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic                         frame_clk,
   input  logic [3:0]                   status,
   input  logic [11:0]                  frame_counter,
   input  logic [9:0]                   GroundY,
   input  logic [NUM_COINS-1:0]         CoinStatus,
   output logic [NUM_COINS-1:0][12:0]   CoinFrameX,
   output logic [NUM_COINS-1:0][9:0]    CoinY,
   output logic [NUM_COINS-1:0]         CoinRespawn,
   output logic [7:0]                   score
);

   logic [2:0]                  sync_q;
   logic                        tick_q;
   logic [15:0]                 lfsr;
   logic                        unused_lfsr_bits;
   state_t                      state_q, state_d;
   logic [NUM_COINS-1:0][12:0]  x_q, x_d;
   logic [NUM_COINS-1:0][9:0]   y_q, y_d;
   logic [NUM_COINS-1:0]        resp_q, resp_d;
   logic [NUM_COINS-1:0]        pend_q, pend_d;
   logic [NUM_COINS-1:0]        cs_q, fall_q;
   logic [7:0]                  score_q, score_d;
   logic [NUM_COINS-1:0]        expired, eligible;
   logic [12:0]                 max_x, new_x;
   logic [13:0]                 cand_a, cand_b, cand;
   logic [9:0]                  y_new;
   logic                        found;

   lfsr16 u_lfsr (
      .Clk     (Clk),
      .Reset   (Reset),
      .en_i    (tick_q),
      .state_o (lfsr)
   );

   assign unused_lfsr_bits = ^lfsr[15:7];

`ifdef COIN_RANDOM_Y_EN
   logic [9:0] y_off;
   always_comb begin
      y_off = 10'd40 + {4'd0, lfsr[4:0], 1'b0};
      y_new = (GroundY < y_off + 10'd20) ? 10'd20 : GroundY - y_off;
   end
`else
   always_comb y_new = (GroundY < 10'd80) ? 10'd20 : GroundY - 10'd60;
`endif

   always_comb begin
      max_x = '0;
      for (int unsigned i = 0; i < NUM_COINS; i++) begin
         expired[i] = ({1'b0, x_q[i]} + 14'(COIN_W)) < {2'b00, frame_counter};
         if (x_q[i] > max_x) max_x = x_q[i];
      end
      cand_a = {1'b0, max_x} + 14'(SPACING_BASE) + {7'd0, lfsr[6:0]};
      cand_b = {2'b00, frame_counter} + 14'(SCREEN_W);
      cand   = (cand_a > cand_b) ? cand_a : cand_b;
      new_x  = (cand > 14'h1FFF) ? 13'h1FFF : cand[12:0];
   end

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      resp_d   = '0;
      pend_d   = pend_q;
      score_d  = score_q;
      found    = 1'b0;
      // A fall landing in the tick cycle is folded into eligibility, so a
      // simultaneous collect and expiry yields a single respawn.
      eligible = expired | pend_q | fall_q;
      case (state_q)
         IDLE: begin
            score_d = '0;
            pend_d  = '0;
            if (status[ST_PLAY])
               state_d = RUN;
            else if (tick_q)
               for (int unsigned i = 0; i < NUM_COINS; i++) begin
                  x_d[i] = 13'(INIT_X_BASE + INIT_X_STEP * i);
                  y_d[i] = y_new;
               end
         end
         RUN: begin
            for (int unsigned i = 0; i < NUM_COINS; i++)
               if (fall_q[i]) begin
                  pend_d[i] = 1'b1;
                  if (score_d != 8'hFF) score_d = score_d + 8'd1;
               end
            if (status[ST_WIN] || status[ST_LOSE])
               state_d = FREEZE;
            else if (tick_q)
               for (int unsigned i = 0; i < NUM_COINS; i++)
                  if (eligible[i] && !found) begin
                     found     = 1'b1;
                     x_d[i]    = new_x;
                     y_d[i]    = y_new;
                     pend_d[i] = 1'b0;
                     resp_d[i] = 1'b1;
                  end
         end
         FREEZE: if (status[ST_WAIT]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync_q  <= '0;
         tick_q  <= 1'b0;
         state_q <= IDLE;
         resp_q  <= '0;
         pend_q  <= '0;
         cs_q    <= '0;
         fall_q  <= '0;
         score_q <= '0;
         for (int unsigned i = 0; i < NUM_COINS; i++) begin
            x_q[i] <= 13'(INIT_X_BASE + INIT_X_STEP * i);
            y_q[i] <= 10'(RESET_Y);
         end
      end else begin
         sync_q  <= {sync_q[1:0], frame_clk};
         tick_q  <= sync_q[1] & ~sync_q[2];
         state_q <= state_d;
         resp_q  <= resp_d;
         pend_q  <= pend_d;
         cs_q    <= CoinStatus;
         fall_q  <= cs_q & ~CoinStatus;
         score_q <= score_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   assign CoinFrameX  = x_q;
   assign CoinY       = y_q;
   assign CoinRespawn = resp_q;
   assign score       = score_q;

endmodule

// File: tb/tb_coin_scheduler.sv
// Scoreboard bench for coin_scheduler: respawn events are predicted into a queue and checked by a monitor.
module tb_coin_scheduler;

   localparam logic [3:0] S_WAIT = 4'b1000;
   localparam logic [3:0] S_PLAY = 4'b0100;
   localparam logic [3:0] S_LOSE = 4'b0001;

   logic             Clk = 1'b0;
   logic             Reset;
   logic             frame_clk;
   logic [3:0]       status;
   logic [11:0]      frame_counter;
   logic [9:0]       GroundY;
   logic [2:0]       CoinStatus;
   logic [2:0][12:0] CoinFrameX;
   logic [2:0][9:0]  CoinY;
   logic [2:0]       CoinRespawn;
   logic [7:0]       score;

   typedef struct {
      logic [2:0] mask;
      int         slot;
      int         x;
      int         y;
      int         sc;
   } exp_t;

   exp_t        exp_q[$];
   int          total = 0;
   int          passed = 0;
   int          xm[3];
   int          ym[3];
   bit          pend_m[3];
   int          sm = 0;
   logic [15:0] lfsr_m = 16'hACE1;

   always #10 Clk = ~Clk;

   coin_scheduler #(.NUM_COINS(3), .SCREEN_W(640), .COIN_W(16)) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .frame_clk     (frame_clk),
      .status        (status),
      .frame_counter (frame_counter),
      .GroundY       (GroundY),
      .CoinStatus    (CoinStatus),
      .CoinFrameX    (CoinFrameX),
      .CoinY         (CoinY),
      .CoinRespawn   (CoinRespawn),
      .score         (score)
   );

   task automatic chk(input string name, input int act, input int expv);
      total++;
      if (act == expv) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, expv);
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] q);
      return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
   endfunction

   function automatic int y_exp(input int g, input logic [15:0] l);
`ifdef COIN_RANDOM_Y_EN
      int off;
      off = 40 + 2 * int'(l[4:0]);
      return (g < off + 20) ? 20 : g - off;
`else
      return (g < 80) ? 20 : g - 60;
`endif
   endfunction

   // mode 0: IDLE layout load, 1: RUN respawn, 2: no positional effect
   task automatic model_tick(input int mode);
      int sel, mx, cand, fc;
      exp_t e;
      sel = -1;
      mx  = 0;
      fc  = int'(frame_counter);
      if (mode == 0) begin
         for (int i = 0; i < 3; i++) begin
            xm[i] = 400 + 200 * i;
            ym[i] = y_exp(int'(GroundY), lfsr_m);
         end
      end else if (mode == 1) begin
         for (int i = 0; i < 3; i++) begin
            if (sel < 0 && ((xm[i] + 16 < fc) || pend_m[i])) sel = i;
            if (xm[i] > mx) mx = xm[i];
         end
         if (sel >= 0) begin
            cand = mx + 120 + int'(lfsr_m[6:0]);
            if (cand < fc + 640) cand = fc + 640;
            if (cand > 8191) cand = 8191;
            xm[sel]     = cand;
            ym[sel]     = y_exp(int'(GroundY), lfsr_m);
            pend_m[sel] = 1'b0;
            e.mask = 3'(1 << sel);
            e.slot = sel;
            e.x    = cand;
            e.y    = ym[sel];
            e.sc   = sm;
            exp_q.push_back(e);
         end
      end
      lfsr_m = lfsr_next(lfsr_m);
   endtask

   task automatic do_tick(input int mode);
      model_tick(mode);
      @(negedge Clk) frame_clk = 1'b1;
      repeat (4) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   // Status change arrives in the same cycle the tick is seen by the FSM.
   task automatic tick_with_status(input logic [3:0] st);
      model_tick(2);
      @(negedge Clk) frame_clk = 1'b1;
      repeat (3) @(posedge Clk);
      @(negedge Clk) status = st;
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   task automatic collect(input int slot);
      @(negedge Clk) CoinStatus[slot] = 1'b0;
      pend_m[slot] = 1'b1;
      if (sm < 255) sm++;
      @(negedge Clk) CoinStatus[slot] = 1'b1;
   endtask

   task automatic check_layout(input string tag);
      for (int i = 0; i < 3; i++) begin
         chk({tag, "_x"}, int'(CoinFrameX[i]), xm[i]);
         chk({tag, "_y"}, int'(CoinY[i]), ym[i]);
      end
   endtask

   always @(negedge Clk) begin
      if (!Reset && CoinRespawn != 3'b000) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_respawn", int'(CoinRespawn), 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("respawn_mask", int'(CoinRespawn), int'(e.mask));
            chk("respawn_x", int'(CoinFrameX[e.slot]), e.x);
            chk("respawn_y", int'(CoinY[e.slot]), e.y);
            chk("respawn_score", int'(score), e.sc);
         end
      end
   end

   initial begin
      Reset = 1'b1; frame_clk = 1'b0; status = S_WAIT; frame_counter = '0;
      GroundY = 10'd400; CoinStatus = 3'b111;
      for (int i = 0; i < 3; i++) begin xm[i] = 400 + 200 * i; ym[i] = 360; pend_m[i] = 1'b0; end
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      check_layout("reset");
      chk("reset_score", int'(score), 0);
      chk("reset_respawn", int'(CoinRespawn), 0);

      do_tick(0); check_layout("idle_g400");
      GroundY = 10'd60; do_tick(0); check_layout("idle_g60");
      GroundY = 10'd80; do_tick(0); check_layout("idle_g80");
      GroundY = 10'd81; do_tick(0); check_layout("idle_g81");
      GroundY = 10'd400; do_tick(0); check_layout("idle_g400b");

      status = S_PLAY;
      repeat (2) @(negedge Clk);
      collect(1);
      @(negedge Clk);
      chk("collect_score", int'(score), 1);
      do_tick(1); check_layout("collect");

      frame_counter = 12'd416; do_tick(1); check_layout("edge416");
      frame_counter = 12'd417; do_tick(1); check_layout("scroll417");
      chk("scroll_score", int'(score), 1);

      frame_counter = 12'd817;
      collect(2);
      @(negedge Clk);
      do_tick(1); check_layout("collect_expire");
      chk("collect_expire_score", int'(score), 2);
      do_tick(1); check_layout("after_single");

      frame_counter = 12'd2000;
      do_tick(1); do_tick(1); do_tick(1); check_layout("multi_expire");
      do_tick(1); check_layout("multi_settled");

      for (int n = 0; n < 260; n++) collect(2);
      repeat (2) @(negedge Clk);
      chk("score_saturate", int'(score), 255);

      tick_with_status(S_LOSE);
      check_layout("freeze_entry");
      collect(0);
      sm = 255;
      do_tick(2); do_tick(2);
      check_layout("freeze_hold");
      chk("freeze_score", int'(score), 255);

      status = S_WAIT;
      repeat (2) @(negedge Clk);
      chk("idle_score_clear", int'(score), 0);
      sm = 0;
      for (int i = 0; i < 3; i++) pend_m[i] = 1'b0;
      do_tick(0); check_layout("restore");

      for (int n = 0; n < 32; n++) begin
         do_tick(0);
         for (int i = 0; i < 3; i++) begin
            chk("yfn_exact", int'(CoinY[i]), ym[i]);
`ifdef COIN_RANDOM_Y_EN
            chk("yfn_range", int'(CoinY[i] >= 10'd298 && CoinY[i] <= 10'd360), 1);
            chk("yfn_even", int'(CoinY[i][0]), 0);
`endif
         end
      end

      repeat (4) @(negedge Clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/coin_scheduler.md
# coin_scheduler

Sequences the three coin slots for the stickman runner. It places each coin in frame coordinates, retires coins that have been collected or have scrolled off the left edge, and respawns them ahead of the player with pseudo-random spacing. It also keeps the score. It sits between the game FSM (which supplies `status` and per-coin `CoinStatus`) and the background renderer (which consumes `CoinFrameX`/`CoinY`). It is advanced once per `frame_clk` tick.

## Interface
Parameters:
- `NUM_COINS`, 3: number of coin slots.
- `SCREEN_W`, 640: visible width in pixels; respawn lower bound.
- `COIN_W`, 16: coin width in pixels; used for the off-screen test.

Ports (`name  direction  width  meaning`):
- `Clk  in  1`: 50 MHz system clock.
- `Reset  in  1`: synchronous, active-high.
- `frame_clk  in  1`: ~60 Hz frame strobe; asynchronous to `Clk` and synchronized internally.
- `status  in  4`: one-hot game status {wait, play, win, lose}.
- `frame_counter  in  12`: frame X of the screen's left edge.
- `GroundY  in  10`: current ground height in pixels.
- `CoinStatus  in  3`: 1 means the coin is present (not yet collected).
- `CoinFrameX  out  13 x NUM_COINS`: frame X of each coin.
- `CoinY  out  10 x NUM_COINS`: Y of each coin.
- `CoinRespawn  out  3`: one-Clk pulse per slot when it is re-armed. The game FSM uses it to set `CoinStatus[i]`.
- `score  out  8`: coins collected this round; saturates at 255.

## Operation
Frame tick:
- `frame_clk` passes through a 2-flop synchronizer, then a rising-edge detect.
- This produces `tick`, one Clk wide.

LFSR:
- 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, seed 16'hACE1.
- Advances on every `tick` in every state.

FSM states:
- **IDLE**
  - Entered on reset, or from FREEZE when `status` = wait.
  - On each tick, loads the initial layout: `CoinFrameX[i]` = 400+200·i and `CoinY[i]` = `y_fn(i)`.
  - Clears `score`.
  - Goes to RUN when `status` = play.
- **RUN**
  - A slot is *expired* when `CoinFrameX[i]` + `COIN_W` < `frame_counter` (zero-extended to 13 bits).
  - A slot is *collected* when its `CoinStatus[i]` falls from 1 to 0. A registered copy of `CoinStatus` is used to detect the edge.
  - A collected slot increments `score` (saturating) and is marked *pending*.
  - On each tick, at most one slot respawns: the lowest-index slot that is expired or pending. Other eligible slots wait for later ticks.
  - New X = max(max_i `CoinFrameX[i]` + spacing, `frame_counter` + `SCREEN_W`), saturating at 13'h1FFF.
  - spacing = 120 + `lfsr[6:0]`, giving 120..247.
  - New Y = `y_fn`. The slot's pending flag clears and `CoinRespawn[i]` pulses.
  - Goes to FREEZE when `status` = win or lose.
- **FREEZE**
  - Holds all positions and `score`.
  - Ignores `CoinStatus` falls.
  - Goes to IDLE when `status` = wait.

`y_fn` (the coin Y function):
- Default: `GroundY` − 60.
- If `GroundY` < 80, the result is clamped to 20.

Edge cases:
- A collect and an expiry of the same slot in the same cycle counts as a single event: score +1 and one respawn.
- If `status` changes in the same cycle as a tick, the state transition wins and no respawn occurs.

## Timing
Reset values:
- State = IDLE.
- `CoinFrameX` = {400, 600, 800}.
- `CoinY` = 360 for all slots.
- `CoinRespawn` = 0, `score` = 0.
- LFSR = 16'hACE1; synchronizer flops = 0; pending flags = 0.

Latencies and pulses:
- `tick` asserts on the 3rd Clk edge after `frame_clk` rises.
- A respawn's new X/Y and its `CoinRespawn` pulse appear together, 1 Clk after `tick`.
- `score` updates 2 Clk after the `CoinStatus` fall (1 Clk for the edge register, 1 Clk for the increment).

All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
Macro: `COIN_RANDOM_Y_EN`.
- **Defined:** `y_fn` = `GroundY` − 40 − 2·`lfsr[4:0]`, giving the range `GroundY`−40 down to `GroundY`−102. The result is clamped to a minimum of 20, and the arithmetic must not underflow.
- **Undefined:** Y is the fixed `GroundY` − 60 described above, and LFSR bits [4:0] are not used for Y.

## Structure
Package `coin_pkg`:
- `NUM_COINS`.
- The spacing base (120) and the initial X base/step (400/200).
- LFSR seed and taps.
- The state enum `{IDLE, RUN, FREEZE}`.

Sub-module `lfsr16`:
- Ports: clock, reset, enable (`tick`), 16-bit state output.
- Reused by later hazard placement.

## Test plan
1. **Reset:** assert `Reset` with `GroundY` = 400. Required: `CoinFrameX` = {400, 600, 800}, `score` = 0. After one tick in wait status, `CoinY` = 340 for all slots (macro off).
2. **Collect:** in play, drop `CoinStatus[1]`, then apply one tick. Required: `score` = 1, a `CoinRespawn` = 3'b010 pulse, and `CoinFrameX[1]` = 800 + 120 + `lfsr[6:0]`.
3. **Scroll-off:** set `frame_counter` = 417 with slot 0 at 400. Required: after the next tick slot 0 is re-placed at or above 1057, and `score` is unchanged.
4. **Simultaneous expiry:** set `frame_counter` = 900 so that slots 0 and 1 both expire. Required: slot 0 respawns on the first tick and slot 1 on the second, with one `CoinRespawn` pulse each.
5. **Freeze:** set `status` = lose, then drop `CoinStatus` and apply ticks. Required: positions and `score` are held. Returning to wait clears `score` and restores the initial layout.
6. **Macro on:** apply 32 ticks with `GroundY` = 400. Required: every `CoinY` lies within [298, 360] and is even.
